// File: rtl/rmii_rx.sv
// RMII receiver: hunts preamble/SFD, assembles LSB-first dibits into bytes and
// streams them with a one-byte lag so the final byte can carry rx_last/rx_err.
// Optional CRC-32 FCS checker is built only when RMII_RX_CRC_EN is defined.
module rmii_rx (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  eth_rxd,
  input  logic        eth_crs_dv,
  input  logic        eth_rx_err,
  output logic        rx_vld,
  output logic [7:0]  rx_data,
  output logic [10:0] rx_addr,
  output logic        rx_last,
  output logic        rx_err,
  output logic        rx_crc_ok,
  output logic        rx_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [11:0] MAX_BYTES = 12'd2048;
  localparam logic [11:0] MIN_BYTES = 12'd5;

  logic [1:0]  state_q, state_d;
  logic        crs_q;
  logic        seen01_q, seen01_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [5:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic [11:0] bcnt_q, bcnt_d;
  logic        ferr_q, ferr_d;
  logic        vld_q, vld_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [7:0]  data_q, data_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  byte_w;
  logic        frame_start;
  logic        byte_commit;

  assign byte_w = {eth_rxd, shift_q};

  // Frame sequencing; the held byte goes out when its successor completes or carrier drops.
  always_comb begin
    state_d     = state_q;
    seen01_d    = seen01_q;
    dcnt_d      = dcnt_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    vld_d       = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    data_d      = data_q;
    addr_d      = addr_q;
    frame_start = 1'b0;
    byte_commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eth_crs_dv && !crs_q) begin
          state_d  = ST_HUNT;
          seen01_d = 1'b0;
        end
      end
      ST_HUNT: begin
        if (!eth_crs_dv) begin
          state_d = ST_IDLE;
        end else if (eth_rxd == 2'b01) begin
          seen01_d = 1'b1;
        end else if (eth_rxd == 2'b11 && seen01_q) begin
          state_d     = ST_DATA;
          frame_start = 1'b1;
          dcnt_d      = 2'd0;
          ferr_d      = 1'b0;
        end else if (eth_rxd[1]) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!eth_crs_dv) begin
          state_d = ST_IDLE;
          if (bcnt_q != 12'd0) begin
            vld_d  = 1'b1;
            last_d = 1'b1;
            data_d = hold_q;
            addr_d = bcnt_q[10:0] - 11'd1;
            err_d  = ferr_q | eth_rx_err | (dcnt_q != 2'd0) | (bcnt_q < MIN_BYTES);
          end
        end else begin
          ferr_d  = ferr_q | eth_rx_err;
          shift_d = {eth_rxd, shift_q[5:2]};
          dcnt_d  = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            // A byte beyond the maximum frame closes the frame in error on the held byte.
            if (bcnt_q == MAX_BYTES) begin
              vld_d   = 1'b1;
              last_d  = 1'b1;
              err_d   = 1'b1;
              data_d  = hold_q;
              addr_d  = bcnt_q[10:0] - 11'd1;
              state_d = ST_DROP;
            end else begin
              byte_commit = 1'b1;
              if (bcnt_q != 12'd0) begin
                vld_d  = 1'b1;
                data_d = hold_q;
                addr_d = bcnt_q[10:0] - 11'd1;
              end
            end
          end
        end
      end
      ST_DROP: begin
        if (!eth_crs_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    bcnt_d = bcnt_q;
    if (frame_start) begin
      bcnt_d = 12'd0;
    end else if (byte_commit) begin
      hold_d = byte_w;
      bcnt_d = bcnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      crs_q    <= 1'b1;
      seen01_q <= 1'b0;
      dcnt_q   <= 2'd0;
      shift_q  <= 6'd0;
      hold_q   <= 8'd0;
      bcnt_q   <= 12'd0;
      ferr_q   <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 8'd0;
      addr_q   <= 11'd0;
    end else begin
      state_q  <= state_d;
      crs_q    <= eth_crs_dv;
      seen01_q <= seen01_d;
      dcnt_q   <= dcnt_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      bcnt_q   <= bcnt_d;
      ferr_q   <= ferr_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      err_q    <= err_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
    end
  end

`ifdef RMII_RX_CRC_EN
  logic [31:0] crc_q, crc_d;
  logic        crcok_q, crcok_d;

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The register already holds every committed byte when the frame closes.
  always_comb begin
    crc_d   = crc_q;
    crcok_d = last_d & (crc_q == 32'hDEBB20E3);
    if (frame_start) begin
      crc_d = 32'hFFFFFFFF;
    end else if (byte_commit) begin
      crc_d = crcByte(crc_q, byte_w);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc_q   <= 32'hFFFFFFFF;
      crcok_q <= 1'b0;
    end else begin
      crc_q   <= crc_d;
      crcok_q <= crcok_d;
    end
  end

  assign rx_crc_ok = crcok_q;
`else
  assign rx_crc_ok = last_q;
`endif

  assign rx_vld  = vld_q;
  assign rx_data = data_q;
  assign rx_addr = addr_q;
  assign rx_last = last_q;
  assign rx_err  = err_q;
  assign rx_busy = (state_q == ST_DATA) | last_q;

endmodule

// File: doc/rmii_rx.md
RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 SHALL have port clk  in  1  single system clock; one RMII dibit is sampled per rising edge.
REQ-002 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port eth_rxd  in  2  RMII receive dibit, LSB-first within each byte.
REQ-004 SHALL have port eth_crs_dv  in  1  carrier/data valid, treated as a plain frame-valid level.
REQ-005 SHALL have port eth_rx_err  in  1  PHY receive error.
REQ-006 SHALL have port rx_vld  out  1  one-cycle pulse; rx_data/rx_addr valid.
REQ-007 SHALL have port rx_data  out  8  received byte, destination MAC through FCS.
REQ-008 SHALL have port rx_addr  out  11  byte index of rx_data within the frame, first byte = 0.
REQ-009 SHALL have port rx_last  out  1  qualifies the final rx_vld of a frame.
REQ-010 SHALL have port rx_err  out  1  frame error, valid only with rx_last.
REQ-011 SHALL have port rx_crc_ok  out  1  FCS check passed, valid only with rx_last.
REQ-012 SHALL have port rx_busy  out  1  high from SFD detection through the rx_last cycle.

Function
REQ-013 SHALL register eth_crs_dv into crs_q and run the FSM states IDLE, HUNT, DATA and DROP.
REQ-014 IDLE -> HUNT SHALL occur only when eth_crs_dv=1 and crs_q=0 (rising edge).
REQ-015 In HUNT, dibits 00 and 01 SHALL be ignored; dibit 11 after at least one 01 SHALL go to DATA with dibit count 0 and assert rx_busy; dibit 10, or 11 with no prior 01, SHALL go to DROP.
REQ-016 In DATA, dibits SHALL shift into a byte LSB-first; the fourth dibit completes a byte.
REQ-017 Each completed byte SHALL be held one byte-time, and the held byte SHALL be emitted on rx_vld when the next byte completes, 1 clk after its fourth dibit is sampled.
REQ-018 When eth_crs_dv is sampled low in DATA, the held byte (if any) SHALL be emitted with rx_last=1 on the next clk, and the FSM SHALL go to IDLE.
REQ-019 rx_addr SHALL increment per emitted byte and saturate nowhere; the maximum frame size is 2048 bytes.
REQ-020 A completed byte at count 2048 SHALL force rx_last=1 and rx_err=1 on byte 2047, and the FSM SHALL go to DROP.
REQ-021 rx_err at rx_last SHALL be the OR of: eth_rx_err sampled high anytime in DATA (sticky), crs_dv falling with dibit count != 0, or fewer than 5 bytes received.
REQ-022 The CRC SHALL be CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF), updated per completed byte over all bytes including FCS; rx_crc_ok=1 SHALL mean the final register equals 0xDEBB20E3.
REQ-023 If crs_dv falls with no completed byte, there SHALL be no rx_vld, rx_busy SHALL drop, and the FSM SHALL go to IDLE.
REQ-024 DROP SHALL wait for eth_crs_dv=0 and then go to IDLE, producing no outputs.
REQ-025 rx_err and rx_crc_ok SHALL be 0 whenever rx_last=0.

Reset
REQ-026 Asserting resetn SHALL immediately force state IDLE, crs_q=1, rx_vld=0, rx_last=0, rx_err=0, rx_crc_ok=0, rx_busy=0, rx_data=0, rx_addr=0, CRC=0xFFFFFFFF.
REQ-027 A frame in progress at reset SHALL be discarded; because crs_q=1, reception SHALL resume only after eth_crs_dv is next seen low.

Configuration
REQ-028 Macro RMII_RX_CRC_EN SHALL control the CRC checker: when defined, CRC logic is per REQ-022.
REQ-029 When RMII_RX_CRC_EN is not defined, no CRC logic SHALL be built, and rx_crc_ok SHALL equal rx_last (unchecked).

Verification
REQ-030 Preamble 55x7, SFD D5, then bytes A1 B2 C3 D4 E5 DF F9 C3 9A -> 9 rx_vld, rx_addr 0..8, last=9A, rx_crc_ok=1, rx_err=0.
REQ-031 Same frame with E5 changed to E4 -> 9 bytes, rx_crc_ok=0, rx_err=0.
REQ-032 Same frame with crs_dv dropped 2 dibits into the last byte -> 8 bytes, the 8th is C3 with rx_last=1, rx_err=1.
REQ-033 eth_rx_err pulsed 1 clk during byte 3 -> all 9 bytes emitted, rx_err=1 at rx_last.
REQ-034 resetn pulsed low at byte 4 with crs_dv held high to frame end, then the valid frame is resent -> first frame produces no output, second is as in REQ-030.
REQ-035 Preamble with dibit 10 before SFD -> no rx_vld, rx_busy stays 0; the next valid frame is received correctly.
